// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// State encoding kept as plain constants for legacy tools.
package pc_pkg;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t HOLD     = 2'd0;
    localparam pc_state_t RUN      = 2'd1;
    localparam pc_state_t REDIRECT = 2'd2;

    localparam int          PC_WIDTH       = 16;
    localparam int          PC_STEP        = 1;
    localparam logic [15:0] PC_RESET_VEC   = 16'h0000;
    localparam int          PC_STACK_DEPTH = 4;

endpackage

// File: rtl/pc_link_stack.sv
// Circular LIFO of return addresses; a push when full drops the oldest.
// ovf/unf are registered one-cycle pulses.
module pc_link_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;
    logic [PW:0]      count;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= push && full;
            unf <= pop && empty;
            if (push) begin
                // ptr wraps onto the oldest slot once full
                ptr <= ptr + PW'(1);
                if (!full)
                    count <= count + (PW+1)'(1);
            end else if (pop && !empty) begin
                ptr   <= top_idx;
                count <= count - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: next-PC select, redirect flush, fetch qualifier.
// Define PC_LINK_STACK_EN to build the return-address link stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter int               STEP        = PC_STEP,
    parameter logic [WIDTH-1:0] RESET_VEC   = PC_RESET_VEC,
    parameter int               STACK_DEPTH = PC_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             fetch_valid,
    output logic             flush,
    output logic             stack_ovf,
    output logic             stack_unf
);

    pc_state_t        state;
    logic             accept;
    logic             redirect;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] pc_next;

    assign pc_plus     = pc + WIDTH'(STEP);
    assign accept      = (state == RUN) && adv && !stall;
    assign redirect    = ret || call || jmp || br_taken;
    assign fetch_valid = (state == RUN);
    assign flush       = (state == REDIRECT);

`ifdef PC_LINK_STACK_EN
    logic             ls_empty;
    logic             ls_full;
    logic [WIDTH-1:0] ls_top;

    pc_link_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (accept && call && !ret),
        .pop   (accept && ret),
        .din   (pc_plus),
        .top   (ls_top),
        .empty (ls_empty),
        .full  (ls_full),
        .ovf   (stack_ovf),
        .unf   (stack_unf)
    );

    assign ret_addr = ls_empty ? ret_target : ls_top;
`else
    assign ret_addr  = ret_target;
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    always_comb begin
        pc_next = pc_plus;
        if (ret)
            pc_next = ret_addr;
        else if (call || jmp)
            pc_next = jmp_target;
        else if (br_taken)
            pc_next = pc_plus + br_offset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_VEC;
            state <= HOLD;
        end else begin
            unique case (state)
                HOLD:     state <= RUN;
                RUN: begin
                    if (accept) begin
                        pc <= pc_next;
                        if (redirect)
                            state <= REDIRECT;
                    end
                end
                // pc holds so the redirect target is fetched on return to RUN
                REDIRECT: state <= RUN;
                default:  state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; covers both link-stack build options.
module tb_pc_sequencer;

`ifdef PC_LINK_STACK_EN
    localparam bit LS = 1'b1;
`else
    localparam bit LS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        adv;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jmp;
    logic [15:0] jmp_target;
    logic        call;
    logic        ret;
    logic [15:0] ret_target;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        fetch_valid;
    logic        flush;
    logic        stack_ovf;
    logic        stack_unf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .adv         (adv),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .call        (call),
        .ret         (ret),
        .ret_target  (ret_target),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic fv,
                             input logic fl);
        chk({tag, ".fv"}, 32'(fetch_valid), 32'(fv));
        chk({tag, ".flush"}, 32'(flush), 32'(fl));
    endtask

    // one redirect request, then the REDIRECT bubble back into RUN
    task automatic redirect_to(input string tag, input logic [15:0] exp_pc);
        tick();
        chk({tag, ".pc"}, 32'(pc), 32'(exp_pc));
        chk_flags(tag, 1'b0, 1'b1);
        {jmp, call, ret, br_taken} = '0;
        tick();
        chk_flags({tag, ".run"}, 1'b1, 1'b0);
    endtask

    logic [15:0] call_tgt [5];
    logic [15:0] ret_exp  [5];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        call_tgt = '{16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
        ret_exp  = '{16'h0501, 16'h0401, 16'h0301, 16'h0201, 16'h0ABC};
        reset = 1'b1; adv = 1'b1; stall = 1'b0;
        br_taken = 1'b0; br_offset = '0;
        jmp = 1'b0; jmp_target = '0; call = 1'b0; ret = 1'b0;
        ret_target = '0;
        tick(); tick();
        chk("rst.pc", 32'(pc), 32'h0000);
        chk_flags("rst", 1'b0, 1'b0);
        chk("rst.ovf", 32'(stack_ovf), 0);
        chk("rst.unf", 32'(stack_unf), 0);

        reset = 1'b0;
        tick();
        chk("hold.pc", 32'(pc), 32'h0000);
        chk_flags("hold", 1'b1, 1'b0);
        tick();
        chk("run1.pc", 32'(pc), 32'h0001);
        tick();
        chk("run2.pc", 32'(pc), 32'h0002);
        chk("run2.plus", 32'(pc_plus), 32'h0003);
        for (int i = 0; i < 14; i++) tick();
        chk("run16.pc", 32'(pc), 32'h0010);

        br_taken = 1'b1; br_offset = 16'h0005;
        tick();
        chk("br.pc", 32'(pc), 32'h0016);
        chk_flags("br", 1'b0, 1'b1);
        br_taken = 1'b0;
        jmp = 1'b1; jmp_target = 16'h0ABC;
        tick();
        chk("redir_ign.pc", 32'(pc), 32'h0016);
        chk_flags("redir_ign", 1'b1, 1'b0);

        jmp = 1'b1; jmp_target = 16'h0020;
        redirect_to("jmp", 16'h0020);
        call = 1'b1; jmp_target = 16'h0100; ret_target = 16'h0021;
        redirect_to("call", 16'h0100);
        ret = 1'b1;
        redirect_to("ret", 16'h0021);
        chk("ret.unf", 32'(stack_unf), 0);

        for (int i = 0; i < 5; i++) begin
            call = 1'b1; jmp_target = call_tgt[i];
            tick();
            chk($sformatf("ncall%0d.pc", i), 32'(pc), 32'(call_tgt[i]));
            chk($sformatf("ncall%0d.ovf", i), 32'(stack_ovf),
                32'(LS && i == 4));
            call = 1'b0;
            tick();
            chk($sformatf("ncall%0d.ovf0", i), 32'(stack_ovf), 0);
        end
        ret_target = 16'h0ABC;
        for (int i = 0; i < 5; i++) begin
            ret = 1'b1;
            tick();
            chk($sformatf("nret%0d.pc", i), 32'(pc),
                32'(LS ? ret_exp[i] : 16'h0ABC));
            chk($sformatf("nret%0d.unf", i), 32'(stack_unf),
                32'(LS && i == 4));
            ret = 1'b0;
            tick();
            chk($sformatf("nret%0d.unf0", i), 32'(stack_unf), 0);
        end

        call = 1'b1; ret = 1'b1; jmp_target = 16'h0777;
        ret_target = 16'h0333;
        redirect_to("callret", 16'h0333);
        ret = 1'b1; ret_target = 16'h0444;
        tick();
        chk("nopush.pc", 32'(pc), 32'h0444);
        chk("nopush.unf", 32'(stack_unf), 32'(LS));
        ret = 1'b0;
        tick();

        jmp = 1'b1; br_taken = 1'b1; jmp_target = 16'h0040;
        br_offset = 16'h0010;
        redirect_to("jmpbr", 16'h0040);
        jmp = 1'b1; jmp_target = 16'h0010;
        redirect_to("jmp10", 16'h0010);
        br_taken = 1'b1; br_offset = 16'hFFF0;
        redirect_to("brneg", 16'h0001);

        adv = 1'b0; br_taken = 1'b1;
        tick();
        chk("noadv.pc", 32'(pc), 32'h0001);
        chk_flags("noadv", 1'b1, 1'b0);
        br_taken = 1'b0; adv = 1'b1;

        jmp = 1'b1; jmp_target = 16'hFFFF;
        redirect_to("jmpff", 16'hFFFF);
        chk("wrap.plus", 32'(pc_plus), 32'h0000);
        tick();
        chk("wrap.pc", 32'(pc), 32'h0000);

        stall = 1'b1; br_taken = 1'b1; br_offset = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d.pc", i), 32'(pc), 32'h0000);
            chk_flags($sformatf("stall%0d", i), 1'b1, 1'b0);
        end
        stall = 1'b0; br_taken = 1'b0;
        tick();
        chk("unstall.pc", 32'(pc), 32'h0001);

        jmp = 1'b1; jmp_target = 16'h0050;
        tick();
        jmp = 1'b0; stall = 1'b1;
        tick();
        chk("stall_redir.pc", 32'(pc), 32'h0050);
        chk_flags("stall_redir", 1'b1, 1'b0);
        stall = 1'b0;

        call = 1'b1; jmp_target = 16'h0060;
        tick();
        chk("rstmid.flush", 32'(flush), 1);
        call = 1'b0; reset = 1'b1;
        tick();
        chk("rstmid.pc", 32'(pc), 32'h0000);
        chk_flags("rstmid", 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        ret = 1'b1; ret_target = 16'h0AAA;
        tick();
        chk("rstmid.ret", 32'(pc), 32'h0AAA);
        chk("rstmid.unf", 32'(stack_unf), 32'(LS));
        ret = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
